// File: rtl/cell_comm_packet_mux.sv
// cell_comm_packet_mux
//   Round-robin merger of NUM_INPUTS AXI-Stream packet sources onto one
//   registered AXI-Stream output (cell-comm TX path, feeds one Aurora lane).
//   Whole packets only, never interleaved. A granted input that starves
//   mid-packet for TIMEOUT_CYCLES is aborted: ABORT_WORD is emitted with
//   tlast and the rest of that source packet is drained and dropped.
//
// Ports
//   ACLK, ARESETN        clock, synchronous active-low reset
//   sAxisTvalid/Tlast    per-input stream handshake / end-of-packet
//   sAxisTdata           input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sAxisTready          per-input ready (only the granted input is ever ready)
//   sArbReqSuppress      per-input: not eligible for a new grant
//   mAxis*               merged registered output stream
//   grantIdx             current / last granted input
//   busy                 arbiter not idle
//   packetCount          forwarded complete packets (saturating)
//   timeoutCount         aborted packets (saturating)
module cell_comm_packet_mux #(
    parameter int                    NUM_INPUTS     = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] ABORT_WORD     = 32'hDEADBEEF,
    parameter int                    COUNTER_WIDTH  = 16
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [NUM_INPUTS-1:0]            sAxisTvalid,
    input  logic [NUM_INPUTS-1:0]            sAxisTlast,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] sAxisTdata,
    output logic [NUM_INPUTS-1:0]            sAxisTready,
    input  logic [NUM_INPUTS-1:0]            sArbReqSuppress,
    output logic                             mAxisTvalid,
    output logic                             mAxisTlast,
    output logic [DATA_WIDTH-1:0]            mAxisTdata,
    input  logic                             mAxisTready,
    output logic [2:0]                       grantIdx,
    output logic                             busy,
    output logic [COUNTER_WIDTH-1:0]         packetCount,
    output logic [COUNTER_WIDTH-1:0]         timeoutCount
);

    // Starve counter only needs to reach TIMEOUT_CYCLES.
    localparam int SW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               grant_q, grant_d;
    logic [SW-1:0]            starve_q, starve_d, starve_inc;
    logic                     tvalid_q, tlast_q;
    logic [DATA_WIDTH-1:0]    tdata_q;
    logic [COUNTER_WIDTH-1:0] pkt_cnt_q, to_cnt_q;

    logic                     out_free;
    logic                     g_valid, g_last, accept, timeout_hit;
    logic [DATA_WIDTH-1:0]    g_data;
    logic [NUM_INPUTS-1:0]    eligible;
    logic                     found;
    logic [2:0]               pick;
    logic                     load, load_last, pkt_inc, to_inc;
    logic [DATA_WIDTH-1:0]    load_data;

    assign out_free    = !tvalid_q || mAxisTready;
    assign eligible    = sAxisTvalid & ~sArbReqSuppress;
    assign starve_inc  = starve_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (starve_inc == SW'(TIMEOUT_CYCLES));

    // Granted-input mux and ready steering.
    always_comb begin
        g_valid     = 1'b0;
        g_last      = 1'b0;
        g_data      = '0;
        sAxisTready = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (grant_q == 3'(j)) begin
                g_valid        = sAxisTvalid[j];
                g_last         = sAxisTlast[j];
                g_data         = sAxisTdata[j*DATA_WIDTH +: DATA_WIDTH];
                sAxisTready[j] = (state_q == PASS && out_free) || (state_q == DRAIN);
            end
        end
    end

    assign accept = g_valid && ((state_q == PASS && out_free) || state_q == DRAIN);

    // Round-robin search: first eligible input after the last grant.
    always_comb begin
        found = 1'b0;
        pick  = grant_q;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            for (int j = 0; j < NUM_INPUTS; j++) begin
                if (!found && eligible[j] && (j == (int'(grant_q) + k) % NUM_INPUTS)) begin
                    found = 1'b1;
                    pick  = 3'(j);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        starve_d  = starve_q;
        load      = 1'b0;
        load_last = 1'b0;
        load_data = g_data;
        pkt_inc   = 1'b0;
        to_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                starve_d = '0;
                if (found) begin
                    grant_d = pick;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (accept) begin
                    // An accepted beat always beats a timeout in the same cycle.
                    load      = 1'b1;
                    load_last = g_last;
                    starve_d  = '0;
                    if (g_last) begin
                        pkt_inc = 1'b1;
                        state_d = IDLE;
                    end
                end else if (!g_valid && out_free) begin
                    // Backpressured cycles are not the source's fault.
                    starve_d = starve_inc;
                    if (timeout_hit) state_d = ABORT;
                end
            end
            ABORT: begin
                starve_d = '0;
                if (out_free) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    load_data = ABORT_WORD;
                    to_inc    = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    starve_d = '0;
                    if (g_last) state_d = IDLE;
                end else begin
                    starve_d = starve_inc;
                    // Second timeout: give up on the tail silently.
                    if (timeout_hit) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            grant_q   <= 3'(NUM_INPUTS - 1);
            starve_q  <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            pkt_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
            if (load) begin
                tvalid_q <= 1'b1;
                tlast_q  <= load_last;
                tdata_q  <= load_data;
            end else if (mAxisTready) begin
                tvalid_q <= 1'b0;
            end
            if (pkt_inc && pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 1'b1;
            if (to_inc && to_cnt_q != '1)   to_cnt_q  <= to_cnt_q + 1'b1;
        end
    end

    assign mAxisTvalid  = tvalid_q;
    assign mAxisTlast   = tlast_q;
    assign mAxisTdata   = tdata_q;
    assign grantIdx     = grant_q;
    assign busy         = (state_q != IDLE);
    assign packetCount  = pkt_cnt_q;
    assign timeoutCount = to_cnt_q;

endmodule
